// File: rtl/stepper_ramp_ctrl_pkg.sv
// ============================================================================
// Module  : stepper_ramp_ctrl_pkg
// Brief   : Shared field layout, limits, state encoding and ramp helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stepper_ramp_ctrl_pkg;

    localparam int LIMIT_W       = 22;
    localparam int LIMIT_MSB     = 21;
    localparam int EN_A_BIT      = 22;
    localparam int EN_B_BIT      = 23;
    localparam int IMM_BIT       = 31;
    localparam int DEF_MIN_LIMIT = 550_000;
    localparam int DEF_MAX_LIMIT = 2_000_000;

    typedef logic [LIMIT_W-1:0] limit_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RAMP     = 2'b01,
        ST_HOLD     = 2'b10,
        ST_STOPPING = 2'b11
    } state_t;

    function automatic limit_t clamp_limit(input limit_t val, input limit_t lo, input limit_t hi);
        if (val < lo) begin
            return lo;
        end else if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

    // Magnitude is compared before subtracting so the step never wraps or overshoots.
    function automatic limit_t step_toward(input limit_t cur, input limit_t tgt, input limit_t step);
        limit_t diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return cur + ((diff < step) ? diff : step);
        end
        diff = cur - tgt;
        return cur - ((diff < step) ? diff : step);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ramp_tick_gen.sv
// ============================================================================
// Module  : ramp_tick_gen
// Brief   : Free-running 0..TICK_CYCLES-1 counter, one-cycle tick on wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ramp_tick_gen #(
    parameter int TICK_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    assign tick = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/stepper_ramp_ctrl.sv
// ============================================================================
// Module  : stepper_ramp_ctrl
// Brief   : Slews the Stepper half-period limit toward a CPU target in fixed
//           steps and issues command words with a one-cycle strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stepper_ramp_ctrl
    import stepper_ramp_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int STEP        = 25_000,
    parameter int MIN_LIMIT   = DEF_MIN_LIMIT,
    parameter int MAX_LIMIT   = DEF_MAX_LIMIT
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] cmd_out,
    output logic        cmd_valid,
    output logic        busy,
    output logic [31:0] status
);

    localparam limit_t C_MIN  = limit_t'(MIN_LIMIT);
    localparam limit_t C_MAX  = limit_t'(MAX_LIMIT);
    localparam limit_t C_STEP = limit_t'(STEP);

    state_t      state_q, state_d;
    limit_t      cur_q, cur_d;
    limit_t      tgt_q, tgt_d;
    logic [1:0]  en_q, en_d;
    logic [31:0] cmd_q, cmd_d;
    logic        valid_q, valid_d;
    logic        start_q, start_d;

    logic        tick;
    limit_t      wr_tgt;
    logic [1:0]  wr_req_en;
    logic        wr_imm;
    logic        unused_wr_bits;

    assign wr_tgt         = clamp_limit(wr_data[LIMIT_MSB:0], C_MIN, C_MAX);
    assign wr_req_en      = {wr_data[EN_B_BIT], wr_data[EN_A_BIT]};
    assign wr_imm         = wr_data[IMM_BIT];
    assign unused_wr_bits = ^wr_data[30:24];

    ramp_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk  (CLK100MHZ),
        .rst  (reset),
        .tick (tick)
    );

    // start_q survives reset so the first post-reset cycle drives the Stepper to disabled.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= C_MAX;
            tgt_q   <= C_MAX;
            en_q    <= 2'b00;
            cmd_q   <= {8'b0, 2'b00, C_MAX};
            valid_q <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            en_q    <= en_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        en_d    = en_q;
        cmd_d   = cmd_q;
        valid_d = start_q;
        start_d = 1'b0;

        // Tick-driven progress uses the registered target; a same-cycle write retargets below.
        case (state_q)
            ST_RAMP: begin
                if (cur_q == tgt_q) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    cur_d   = step_toward(cur_q, tgt_q, C_STEP);
                    valid_d = 1'b1;
                    if (cur_d == tgt_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_STOPPING: begin
                if (cur_q == C_MAX) begin
                    en_d    = 2'b00;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    cur_d   = step_toward(cur_q, tgt_q, C_STEP);
                    valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (wr_en) begin
            if (wr_imm) begin
                tgt_d   = (wr_req_en == 2'b00) ? C_MAX : wr_tgt;
                cur_d   = tgt_d;
                en_d    = wr_req_en;
                valid_d = 1'b1;
                state_d = (wr_req_en == 2'b00) ? ST_IDLE : ST_HOLD;
            end else if (wr_req_en == 2'b00) begin
                tgt_d = C_MAX;
                if (state_q != ST_IDLE) begin
                    state_d = ST_STOPPING;
                end
            end else begin
                tgt_d = wr_tgt;
                en_d  = wr_req_en;
                if (wr_req_en != en_q) begin
                    valid_d = 1'b1;
                end
                state_d = (cur_d == wr_tgt) ? ST_HOLD : ST_RAMP;
            end
        end

        if (valid_d) begin
            cmd_d = {8'b0, en_d, cur_d};
        end
    end

    always_comb begin
        busy      = (state_q == ST_RAMP) || (state_q == ST_STOPPING);
        cmd_out   = cmd_q;
        cmd_valid = valid_q;
        status    = {busy, state_q, 5'b0, en_q, cur_q};
    end

endmodule

`default_nettype wire

// File: tb/tb_stepper_ramp_ctrl.sv
// ============================================================================
// Module  : tb_stepper_ramp_ctrl
// Brief   : Directed vector table plus ramp sequences for stepper_ramp_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stepper_ramp_ctrl;

    logic        CLK100MHZ;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] cmd_out;
    logic        cmd_valid;
    logic        busy;
    logic [31:0] status;

    int total = 0;
    int bad   = 0;
    logic [31:0] q[$];
    logic [31:0] expq[$];

    typedef struct {
        logic [31:0] data;
        bit          exp_strobe;
        logic [31:0] exp_cmd;
        logic [1:0]  exp_state;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    stepper_ramp_ctrl #(
        .TICK_CYCLES (10),
        .STEP        (100_000),
        .MIN_LIMIT   (550_000),
        .MAX_LIMIT   (2_000_000)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .status    (status)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(negedge CLK100MHZ) begin
        if (cmd_valid) q.push_back(cmd_out);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic write(input logic [31:0] d);
        @(posedge CLK100MHZ);
        #1;
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge CLK100MHZ);
        #1;
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int c = 0;
        while (q.size() < n && c < budget) begin
            @(posedge CLK100MHZ);
            c++;
        end
    endtask

    task automatic check_queue(input string name);
        check({name, "_count"}, q.size(), expq.size());
        for (int i = 0; i < expq.size() && i < q.size(); i++) begin
            check($sformatf("%s_%0d", name, i), q[i], expq[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;

        vecs[0]  = '{32'h80C86470, 1'b1, 32'h00C86470, 2'd2};
        vecs[1]  = '{32'h00C86470, 1'b0, 32'h00C86470, 2'd2};
        vecs[2]  = '{32'h00486470, 1'b1, 32'h00486470, 2'd2};
        vecs[3]  = '{32'hFF486470, 1'b1, 32'h00486470, 2'd2};
        vecs[4]  = '{32'h80400064, 1'b1, 32'h00486470, 2'd2};
        vecs[5]  = '{32'h80FFFFFF, 1'b1, 32'h00DE8480, 2'd2};
        vecs[6]  = '{32'h808F4240, 1'b1, 32'h008F4240, 2'd2};
        vecs[7]  = '{32'h80000000, 1'b1, 32'h001E8480, 2'd0};
        vecs[8]  = '{32'h00000000, 1'b0, 32'h001E8480, 2'd0};
        vecs[9]  = '{32'h80DE8480, 1'b1, 32'h00DE8480, 2'd2};
        vecs[10] = '{32'h001E8480, 1'b1, 32'h001E8480, 2'd0};

        // Reset state and the single post-reset strobe.
        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("reset_status", status, 32'h001E8480);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", cmd_valid, 1'b0);
        q.delete();
        reset = 1'b0;
        repeat (6) @(posedge CLK100MHZ);
        #1;
        expq = '{32'h001E8480};
        check_queue("post_reset");

        for (int i = 0; i < NV; i++) begin
            q.delete();
            write(vecs[i].data);
            repeat (2) @(posedge CLK100MHZ);
            #1;
            check($sformatf("vec%0d_strobes", i), q.size(), vecs[i].exp_strobe ? 1 : 0);
            check($sformatf("vec%0d_cmd", i), cmd_out, vecs[i].exp_cmd);
            check($sformatf("vec%0d_state", i), status[30:29], vecs[i].exp_state);
        end

        // Ramp down from IDLE to the fastest limit.
        q.delete();
        write(32'h00C86470);
        check("down_busy", busy, 1'b1);
        wait_strobes(16, 400);
        repeat (30) @(posedge CLK100MHZ);
        #1;
        expq.delete();
        expq.push_back(32'h00DE8480);
        for (int k = 1; k <= 14; k++) expq.push_back(32'h00C00000 | 32'(2_000_000 - k * 100_000));
        expq.push_back(32'h00C86470);
        check_queue("down");
        check("down_state", status[30:29], 2'd2);
        check("down_busy_end", busy, 1'b0);

        // Graceful stop: ramp up with the old enables, then disable.
        q.delete();
        write(32'h00000000);
        check("stop_state", status[30:29], 2'd3);
        check("stop_busy", busy, 1'b1);
        wait_strobes(16, 400);
        repeat (30) @(posedge CLK100MHZ);
        #1;
        expq.delete();
        for (int k = 1; k <= 14; k++) expq.push_back(32'h00C00000 | 32'(550_000 + k * 100_000));
        expq.push_back(32'h00DE8480);
        expq.push_back(32'h001E8480);
        check_queue("stop");
        check("stop_state_end", status[30:29], 2'd0);

        // Target clamping at both ends.
        q.delete();
        write(32'h00400064);
        wait_strobes(16, 400);
        repeat (30) @(posedge CLK100MHZ);
        #1;
        check("clamp_lo_count", q.size(), 16);
        check("clamp_lo_last", cmd_out, 32'h00486470);
        check("clamp_lo_state", status[30:29], 2'd2);
        q.delete();
        write(32'h006DC6C0);
        wait_strobes(15, 400);
        repeat (30) @(posedge CLK100MHZ);
        #1;
        check("clamp_hi_count", q.size(), 15);
        check("clamp_hi_last", cmd_out, 32'h005E8480);
        check("clamp_hi_state", status[30:29], 2'd2);

        // Emergency stop mid-ramp.
        write(32'h00486470);
        q.delete();
        wait_strobes(3, 100);
        check("estop_pre", q.size(), 3);
        write(32'h80000000);
        q.delete();
        check("estop_valid", cmd_valid, 1'b1);
        check("estop_cmd", cmd_out, 32'h001E8480);
        repeat (40) @(posedge CLK100MHZ);
        #1;
        expq = '{32'h001E8480};
        check_queue("estop");
        check("estop_state", status[30:29], 2'd0);

        // Write coincident with a tick during RAMP.
        write(32'h80DE8480);
        write(32'h00C86470);
        begin
            int c = 0;
            @(negedge CLK100MHZ);
            while (!cmd_valid && c < 40) begin
                @(negedge CLK100MHZ);
                c++;
            end
            check("coin_first", cmd_out, 32'h00DCFDE0);
        end
        repeat (9) @(posedge CLK100MHZ);
        #1;
        wr_en   = 1'b1;
        wr_data = 32'h00DE8480;
        @(posedge CLK100MHZ);
        #1;
        wr_en   = 1'b0;
        wr_data = '0;
        check("coin_valid", cmd_valid, 1'b1);
        check("coin_cmd", cmd_out, 32'h00DB7740);
        @(posedge CLK100MHZ);
        #1;
        check("coin_single", cmd_valid, 1'b0);
        q.delete();
        wait_strobes(2, 100);
        repeat (2) @(posedge CLK100MHZ);
        #1;
        expq = '{32'h00DCFDE0, 32'h00DE8480};
        check_queue("coin_after");
        check("coin_state", status[30:29], 2'd2);

        // Reset asserted mid-ramp.
        write(32'h00C86470);
        q.delete();
        wait_strobes(2, 100);
        @(posedge CLK100MHZ);
        #1;
        reset = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        check("mid_reset_status", status, 32'h001E8480);
        check("mid_reset_busy", busy, 1'b0);
        @(posedge CLK100MHZ);
        #1;
        q.delete();
        reset = 1'b0;
        repeat (6) @(posedge CLK100MHZ);
        #1;
        expq = '{32'h001E8480};
        check_queue("mid_reset_strobe");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
